dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: the pipeline load/store stage (core, port c_) and the program/data loader (port l_).
- Provides:
  - per-cycle round-robin arbitration;
  - loader burst locking;
  - a starvation guard that forces core access during long bursts;
  - registered read-return to the winning requester.
- Sits between the MEM pipeline stage / loader and the data memory; it drives the memory's write_enable, adr and din, and samples its combinational dout.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_starve_counter.sv | 33 +++
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared encodings and sizing helper for the data-memory arbiter.
// Imported by the arbiter top and its starvation counter.
package dmem_arb_pkg;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    typedef enum logic {
        OWN_CORE   = 1'b0,
        OWN_LOADER = 1'b1
    } owner_t;

    // Wide enough to hold STARVE_MAX itself; degenerate values still get one bit.
    function automatic int starve_cnt_width(input int starve_max);
        return (starve_max < 1) ? 1 : $clog2(starve_max + 1);
    endfunction

endpackage

// File: rtl/dmem_starve_counter.sv
// Counts consecutive cycles the core is refused while the loader holds a lock.
// Saturates at STARVE_MAX and flags it so the arbiter can force one core cycle.
module dmem_starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int CW = starve_cnt_width(STARVE_MAX);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] cnt_reg;

    // Clear wins over increment; the count never wraps past CNT_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign hit = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core MEM stage and the loader.
// Round-robin per beat, loader burst locking with a core starvation guard.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N          = 32,
    parameter int M          = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         c_req,
    input  logic         c_we,
    input  logic [N-1:0] c_adr,
    input  logic [M-1:0] c_wdata,
    output logic         c_gnt,
    output logic         c_rvalid,
    output logic [M-1:0] c_rdata,
    input  logic         l_req,
    input  logic         l_we,
    input  logic [N-1:0] l_adr,
    input  logic [M-1:0] l_wdata,
    output logic         l_gnt,
    output logic         l_rvalid,
    output logic [M-1:0] l_rdata,
    input  logic         l_lock,
    output logic         mem_we,
    output logic [N-1:0] mem_adr,
    output logic [M-1:0] mem_din,
    input  logic [M-1:0] mem_dout
);

    logic [0:0]   state_reg, state_next;
    owner_t       last_reg, last_next;
    logic         in_lock, forced, starve_hit, lock_exit;
    logic         c_gnt_int, l_gnt_int, c_beat, l_beat;
    logic         cnt_inc, cnt_clr;
    logic         c_rvalid_reg, l_rvalid_reg;
    logic [M-1:0] c_rdata_reg, l_rdata_reg;

    assign in_lock = (state_reg == ST_LOCK);
    assign forced  = in_lock && starve_hit;

    // Grants are suppressed while reset is high so no stray write reaches memory.
    always_comb begin
        c_gnt_int = 1'b0;
        l_gnt_int = 1'b0;
        if (!reset) begin
            if (in_lock) begin
                if (forced) begin
                    c_gnt_int = c_req;
                end else begin
                    l_gnt_int = l_req;
                end
            end else if (c_req && l_req) begin
                c_gnt_int = (last_reg == OWN_LOADER);
                l_gnt_int = (last_reg == OWN_CORE);
            end else begin
                c_gnt_int = c_req;
                l_gnt_int = l_req;
            end
        end
    end

    assign c_beat = c_req && c_gnt_int;
    assign l_beat = l_req && l_gnt_int;

    // Leaving a lock hands the next tie to the core regardless of who moved last.
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        lock_exit  = 1'b0;
        if (c_beat) begin
            last_next = OWN_CORE;
        end
        if (l_beat) begin
            last_next = OWN_LOADER;
        end
        if (!in_lock) begin
            if (l_beat && l_lock) begin
                state_next = ST_LOCK;
            end
        end else if ((l_beat && !l_lock) || (!l_req && !l_lock)) begin
            state_next = ST_ARB;
            last_next  = OWN_LOADER;
            lock_exit  = 1'b1;
        end
    end

    assign cnt_inc = in_lock && c_req && !c_gnt_int;
    assign cnt_clr = !in_lock || !c_req || forced || lock_exit;

    dmem_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .hit   (starve_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_ARB;
            last_reg     <= OWN_LOADER;
            c_rvalid_reg <= 1'b0;
            l_rvalid_reg <= 1'b0;
            c_rdata_reg  <= '0;
            l_rdata_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            last_reg     <= last_next;
            c_rvalid_reg <= c_beat && !c_we;
            l_rvalid_reg <= l_beat && !l_we;
            if (c_beat && !c_we) begin
                c_rdata_reg <= mem_dout;
            end
            if (l_beat && !l_we) begin
                l_rdata_reg <= mem_dout;
            end
        end
    end

    // Idle cycles present the core's address so a core read can start without a mux flip.
    assign mem_we  = (c_beat && c_we) || (l_beat && l_we);
    assign mem_adr = l_gnt_int ? l_adr : c_adr;
    assign mem_din = l_gnt_int ? l_wdata : c_wdata;

    assign c_gnt    = c_gnt_int;
    assign l_gnt    = l_gnt_int;
    assign c_rvalid = c_rvalid_reg;
    assign l_rvalid = l_rvalid_reg;
    assign c_rdata  = c_rdata_reg;
    assign l_rdata  = l_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed table, corner-case sequences and random traffic,
// all scored against a shadow-memory model of the sharing rules.
module tb_dmem_arbiter;

    localparam int   SMAX = 8;
    localparam logic H    = 1'b1;
    localparam logic L    = 1'b0;

    logic        clk, reset;
    logic        c_req, c_we, c_gnt, c_rvalid;
    logic [31:0] c_adr, c_wdata, c_rdata;
    logic        l_req, l_we, l_lock, l_gnt, l_rvalid;
    logic [31:0] l_adr, l_wdata, l_rdata;
    logic        mem_we;
    logic [31:0] mem_adr, mem_din, mem_dout;

    dmem_arbiter #(.N(32), .M(32), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_adr(l_adr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_lock(l_lock),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with combinational read; preload port used only during initial reset.
    logic [31:0] mem [64];
    logic        pre_en;
    logic [5:0]  pre_adr;
    logic [31:0] pre_dat;
    assign mem_dout = mem[mem_adr[5:0]];
    always @(posedge clk) begin
        if (pre_en) mem[pre_adr] <= pre_dat;
        else if (mem_we) mem[mem_adr[5:0]] <= mem_din;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: who owns the memory, who wins the next tie, how long the core waited.
    logic [31:0] shadow [64];
    bit          m_locked, m_core_first, m_crv, m_lrv;
    int          m_wait;
    logic [31:0] m_crd, m_lrd;
    bit          e_cg, e_lg;

    task automatic m_reset();
        m_locked = 0; m_core_first = 1; m_wait = 0;
        m_crv = 0; m_lrv = 0; m_crd = '0; m_lrd = '0;
    endtask

    task automatic idle();
        reset = 1'b0; c_req = 1'b0; c_we = 1'b0; c_adr = '0; c_wdata = '0;
        l_req = 1'b0; l_we = 1'b0; l_lock = 1'b0; l_adr = '0; l_wdata = '0;
    endtask

    // Called just after a falling edge with inputs applied.
    task automatic cycle_begin();
        #1;
        e_cg = 0; e_lg = 0;
        if (!reset) begin
            if (!m_locked) begin
                if (c_req && l_req) begin
                    e_cg = m_core_first; e_lg = !m_core_first;
                end else begin
                    e_cg = c_req; e_lg = l_req;
                end
            end else if (m_wait >= SMAX) begin
                e_cg = c_req;
            end else begin
                e_lg = l_req;
            end
        end
        chk1("c_gnt", c_gnt, e_cg);
        chk1("l_gnt", l_gnt, e_lg);
        chk1("mem_we", mem_we, (e_cg && c_we) || (e_lg && l_we));
        chk32("mem_adr", mem_adr, e_lg ? l_adr : c_adr);
        chk32("mem_din", mem_din, e_lg ? l_wdata : c_wdata);
        chk1("c_rvalid", c_rvalid, !reset && m_crv);
        chk1("l_rvalid", l_rvalid, !reset && m_lrv);
        if (reset || m_crv) chk32("c_rdata", c_rdata, reset ? 32'h0 : m_crd);
        if (reset || m_lrv) chk32("l_rdata", l_rdata, reset ? 32'h0 : m_lrd);
    endtask

    task automatic cycle_end();
        if (c_gnt) $display("%0t core %s adr=%0h", $time, c_we ? "wr" : "rd", c_adr);
        if (l_gnt) $display("%0t ldr  %s adr=%0h lock=%0b", $time, l_we ? "wr" : "rd", l_adr, l_lock);
        if (reset) begin
            m_reset();
        end else begin
            m_crv = e_cg && !c_we;
            m_lrv = e_lg && !l_we;
            if (e_cg) begin
                if (c_we) shadow[c_adr[5:0]] = c_wdata;
                else m_crd = shadow[c_adr[5:0]];
                m_core_first = 0;
            end
            if (e_lg) begin
                if (l_we) shadow[l_adr[5:0]] = l_wdata;
                else m_lrd = shadow[l_adr[5:0]];
                m_core_first = 1;
            end
            if (!m_locked) begin
                m_locked = e_lg && l_lock;
            end else if ((e_lg && !l_lock) || (!l_req && !l_lock)) begin
                m_locked = 0; m_wait = 0; m_core_first = 1;
            end else if (c_req && !e_cg) begin
                m_wait++;
            end else begin
                m_wait = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst, c_req, c_we;
        logic [31:0] c_adr, c_wdata;
        logic        l_req, l_we, l_lock;
        logic [31:0] l_adr, l_wdata;
        logic        e_cg, e_lg, e_we, e_crv, e_lrv;
        logic [31:0] e_crd, e_lrd;
    } vec_t;

    localparam int NV = 11;
    vec_t tbl [NV];

    initial begin
        int  beats;
        logic exp_c;

        // rst, c_req,c_we,c_adr,c_wdata, l_req,l_we,l_lock,l_adr,l_wdata, gnt c/l, we, rvalid c/l, rdata c/l
        tbl[0]  = '{L, H,H,8,10, L,L,L,0,0, H,L,H,L,L,0,0};
        tbl[1]  = '{L, H,L,8,0,  L,L,L,0,0, H,L,L,L,L,0,0};
        tbl[2]  = '{L, L,L,0,0,  L,L,L,0,0, L,L,L,H,L,10,0};
        tbl[3]  = '{H, H,H,8,99, L,L,L,0,0, L,L,L,L,L,0,0};
        tbl[4]  = '{L, H,L,3,0,  H,L,L,5,0, H,L,L,L,L,0,0};
        tbl[5]  = '{L, H,L,3,0,  H,L,L,5,0, L,H,L,H,L,32'h1003,0};
        tbl[6]  = '{L, H,L,3,0,  H,L,L,5,0, H,L,L,L,H,0,32'h1005};
        tbl[7]  = '{L, H,L,3,0,  H,L,L,5,0, L,H,L,H,L,32'h1003,0};
        tbl[8]  = '{L, H,L,3,0,  H,L,L,5,0, H,L,L,L,H,0,32'h1005};
        tbl[9]  = '{L, H,L,3,0,  H,L,L,5,0, L,H,L,H,L,32'h1003,0};
        tbl[10] = '{L, L,L,0,0,  L,L,L,0,0, L,L,L,L,H,0,32'h1005};

        idle();
        reset = 1'b1;
        pre_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pre_adr = 6'(i);
            pre_dat = 32'h1000 + i;
            shadow[i] = 32'h1000 + i;
            @(posedge clk);
            #1;
        end
        pre_en = 1'b0;
        m_reset();
        @(negedge clk);

        for (int r = 0; r < NV; r++) begin
            reset = tbl[r].rst;
            c_req = tbl[r].c_req; c_we = tbl[r].c_we; c_adr = tbl[r].c_adr; c_wdata = tbl[r].c_wdata;
            l_req = tbl[r].l_req; l_we = tbl[r].l_we; l_lock = tbl[r].l_lock;
            l_adr = tbl[r].l_adr; l_wdata = tbl[r].l_wdata;
            cycle_begin();
            chk1("tbl_c_gnt", c_gnt, tbl[r].e_cg);
            chk1("tbl_l_gnt", l_gnt, tbl[r].e_lg);
            chk1("tbl_mem_we", mem_we, tbl[r].e_we);
            chk1("tbl_c_rvalid", c_rvalid, tbl[r].e_crv);
            chk1("tbl_l_rvalid", l_rvalid, tbl[r].e_lrv);
            if (tbl[r].e_crv || tbl[r].rst) chk32("tbl_c_rdata", c_rdata, tbl[r].e_crd);
            if (tbl[r].e_lrv || tbl[r].rst) chk32("tbl_l_rdata", l_rdata, tbl[r].e_lrd);
            cycle_end();
        end

        // Loader write burst 0..15 with the core idle: every cycle is a loader beat.
        beats = 0;
        for (int t = 0; t < 40 && beats < 16; t++) begin
            idle();
            l_req = 1'b1; l_we = 1'b1; l_adr = beats; l_wdata = 32'hA000 + beats;
            l_lock = (beats != 15);
            cycle_begin();
            chk1("burst_l_gnt", l_gnt, 1'b1);
            if (l_gnt) beats++;
            cycle_end();
        end
        chk32("burst_beats", beats, 16);
        idle();
        c_req = 1'b1; l_req = 1'b1; c_adr = 32'd30; l_adr = 32'd31;
        cycle_begin();
        chk1("burst_exit_c_gnt", c_gnt, 1'b1);
        cycle_end();

        // Same burst with the core knocking from the second cycle on.
        beats = 0;
        for (int t = 0; t < 60 && beats < 16; t++) begin
            idle();
            c_req = (t > 0); c_adr = 32'd40;
            l_req = 1'b1; l_we = 1'b1; l_adr = beats; l_wdata = 32'hB000 + beats;
            l_lock = (beats != 15);
            exp_c = (t > 0) && (t % (SMAX + 1) == 0);
            cycle_begin();
            chk1("starve_c_gnt", c_gnt, exp_c);
            chk1("starve_l_gnt", l_gnt, !exp_c);
            if (l_gnt) beats++;
            cycle_end();
        end
        chk32("starve_beats", beats, 16);
        idle();
        c_req = 1'b1; c_adr = 32'd40;
        cycle_begin();
        chk1("starve_exit_c_gnt", c_gnt, 1'b1);
        cycle_end();

        // Reset one cycle into a locked loader read burst with a read in flight.
        idle(); l_req = 1'b1; l_adr = 32'd1; l_lock = 1'b1;
        cycle_begin(); cycle_end();
        idle(); l_req = 1'b1; l_adr = 32'd2; l_lock = 1'b1;
        cycle_begin();
        chk1("mid_l_rvalid_pre", l_rvalid, 1'b1);
        cycle_end();
        idle(); reset = 1'b1; c_req = 1'b1; l_req = 1'b1; l_we = 1'b1; l_lock = 1'b1;
        l_adr = 32'd3; l_wdata = 32'hDEAD;
        cycle_begin();
        chk1("mid_rst_l_rvalid", l_rvalid, 1'b0);
        chk32("mid_rst_l_rdata", l_rdata, 32'h0);
        chk1("mid_rst_mem_we", mem_we, 1'b0);
        chk1("mid_rst_l_gnt", l_gnt, 1'b0);
        chk1("mid_rst_c_gnt", c_gnt, 1'b0);
        cycle_end();
        idle(); c_req = 1'b1; l_req = 1'b1; c_adr = 32'd4; l_adr = 32'd5;
        cycle_begin();
        chk1("post_rst_c_gnt", c_gnt, 1'b1);
        chk1("post_rst_l_gnt", l_gnt, 1'b0);
        cycle_end();

        // Loader walks away from a lock without a final beat.
        idle(); l_req = 1'b1; l_we = 1'b1; l_adr = 32'd20; l_wdata = 32'h5A5A; l_lock = 1'b1;
        cycle_begin(); cycle_end();
        idle(); c_req = 1'b1; c_adr = 32'd20;
        cycle_begin();
        chk1("drop_lock_c_gnt", c_gnt, 1'b0);
        cycle_end();
        idle(); c_req = 1'b1; c_adr = 32'd20; l_req = 1'b1; l_adr = 32'd21;
        cycle_begin();
        chk1("drop_next_c_gnt", c_gnt, 1'b1);
        chk1("drop_next_l_gnt", l_gnt, 1'b0);
        cycle_end();
        idle();
        cycle_begin();
        chk1("drop_c_rvalid", c_rvalid, 1'b1);
        chk32("drop_c_rdata", c_rdata, 32'h5A5A);
        cycle_end();

        // Random traffic with occasional resets, scored by the model alone.
        for (int t = 0; t < 500; t++) begin
            reset   = ($urandom_range(0, 99) == 0);
            c_req   = ($urandom_range(0, 2) != 0);
            c_we    = 1'($urandom_range(0, 1));
            c_adr   = 32'($urandom_range(0, 63));
            c_wdata = $urandom;
            l_req   = ($urandom_range(0, 3) != 0);
            l_we    = 1'($urandom_range(0, 1));
            l_lock  = ($urandom_range(0, 4) != 0);
            l_adr   = 32'($urandom_range(0, 63));
            l_wdata = $urandom;
            cycle_begin();
            cycle_end();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
